// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder datapath: the PISO state encoding and the
// operand / result word widths used by the serializer and deserializer.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

  typedef logic [DEFAULT_WIDTH-1:0] piso_word_t;
  typedef logic [DEFAULT_WIDTH-1:0] sipo_word_t;

endpackage

// File: rtl/parallel_serial_if.sv
// Load handshake plus serial stream of the PISO; the slave side is the serializer.
interface parallel_serial_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic [WIDTH-1:0] data_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic             shift_en_i;
  logic             serial_o;
  logic             serial_valid_o;
  logic             last_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output data_i, load_valid_i, shift_en_i,
    input  load_ready_o, serial_o, serial_valid_o, last_o, busy_o, done_o
  );

  modport slave (
    input  data_i, load_valid_i, shift_en_i,
    output load_ready_o, serial_o, serial_valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/parallel_serial.sv
// Parallel-to-serial shifter: accepts a word on a valid/ready load, emits it one
// bit per shift_en_i cycle, flags the last bit and pulses done after it is taken.
module parallel_serial
  import serial_adder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  parallel_serial_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  piso_state_e      r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_valid;
  logic             r_busy;
  logic             r_last;
  logic             r_done;

  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  assign w_accept  = bus.load_valid_i && r_ready;
  // Zero-fill so the serial output settles to 0 once the word has drained.
  assign w_shifted = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

  assign bus.serial_o       = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign bus.load_ready_o   = r_ready;
  assign bus.serial_valid_o = r_valid;
  assign bus.last_o         = r_last;
  assign bus.busy_o         = r_busy;
  assign bus.done_o         = r_done;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_shreg <= bus.data_i;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_last  <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (bus.shift_en_i) begin
            r_shreg <= w_shifted;
            if (r_last) begin
              r_cnt   <= '0;
              r_last  <= 1'b0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_last <= (r_cnt == CW'(WIDTH - 2));
            end
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_last  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_serial.sv
// Randomized bench for parallel_serial: LSB-first and MSB-first instances share
// stimulus and are compared each cycle against a word/bit-position model.
module tb_parallel_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] r_data;
  logic         r_lv;
  logic         r_se;

  always #5 clk = ~clk;

  parallel_serial_if #(.WIDTH(W)) if_l ();
  parallel_serial_if #(.WIDTH(W)) if_m ();

  assign if_l.data_i       = r_data;
  assign if_l.load_valid_i = r_lv;
  assign if_l.shift_en_i   = r_se;
  assign if_m.data_i       = r_data;
  assign if_m.load_valid_i = r_lv;
  assign if_m.shift_en_i   = r_se;

  parallel_serial #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk_i(clk), .reset_n_i(rst_n), .bus(if_l));
  parallel_serial #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk_i(clk), .reset_n_i(rst_n), .bus(if_m));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: the held word, how many bits of it have been consumed, and flags.
  logic [W-1:0] m_word;
  int           m_pos;
  bit           m_active, m_ready, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_word = '0; m_pos = 0; m_active = 0; m_ready = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit fin;
    fin    = m_active && r_se && (m_pos == W - 1);
    m_done = fin;
    if (r_lv && m_ready) begin
      m_word = r_data; m_pos = 0; m_active = 1; m_ready = 0;
    end else if (m_active) begin
      if (r_se) begin
        m_pos++;
        if (fin) begin m_active = 0; m_ready = 1; m_pos = 0; end
      end
    end else begin
      m_ready = 1;
    end
  endtask

  task automatic check_outs();
    logic eb_l, eb_m, el;
    eb_l = m_active ? m_word[m_pos] : 1'b0;
    eb_m = m_active ? m_word[W-1-m_pos] : 1'b0;
    el   = m_active && (m_pos == W - 1);
    chk("l_serial", 32'(if_l.serial_o), 32'(eb_l));
    chk("m_serial", 32'(if_m.serial_o), 32'(eb_m));
    chk("l_valid",  32'(if_l.serial_valid_o), 32'(m_active));
    chk("m_valid",  32'(if_m.serial_valid_o), 32'(m_active));
    chk("l_last",   32'(if_l.last_o), 32'(el));
    chk("m_last",   32'(if_m.last_o), 32'(el));
    chk("l_busy",   32'(if_l.busy_o), 32'(m_active));
    chk("m_busy",   32'(if_m.busy_o), 32'(m_active));
    chk("l_ready",  32'(if_l.load_ready_o), 32'(m_ready));
    chk("m_ready",  32'(if_m.load_ready_o), 32'(m_ready));
    chk("l_done",   32'(if_l.done_o), 32'(m_done));
    chk("m_done",   32'(if_m.done_o), 32'(m_done));
  endtask

  task automatic cycle(input logic lv, input logic [W-1:0] d, input logic se);
    r_lv = lv; r_data = d; r_se = se;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  // Load a word, then shift n cycles with se; collects the bits each instance emits.
  task automatic run_word(input logic [W-1:0] d, input int n, output logic [W-1:0] got_l,
                          output logic [W-1:0] got_m);
    got_l = '0; got_m = '0;
    cycle(1'b1, d, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i < W) begin
        got_l[i]       = if_l.serial_o;
        got_m[W-1-i]   = if_m.serial_o;
      end
      cycle(1'b0, W'($urandom), 1'b1);
    end
  endtask

  initial begin
    logic [W-1:0] gl, gm;
    rst_n = 1'b0; r_lv = 1'b0; r_se = 1'b0; r_data = '0;
    model_reset();
    #12;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_pre_edge", 32'(if_l.load_ready_o), 32'd0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, 8'h5A, 1'b1);

    run_word(8'hA5, W + 1, gl, gm);
    chk("a5_lsb_word", 32'(gl), 32'hA5);
    chk("a5_msb_word", 32'(gm), 32'hA5);
    run_word(8'h0F, W + 2, gl, gm);
    chk("0f_lsb_word", 32'(gl), 32'h0F);
    chk("0f_msb_word", 32'(gm), 32'h0F);

    // Stall mid-word after three bits have been taken.
    cycle(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, W'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, W'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, W'($urandom), 1'b1);

    // Back-to-back loads with load_valid held high.
    cycle(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'hFF, 1'b1);

    // Asynchronous reset in the middle of a word.
    cycle(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outs();
    @(negedge clk);
    check_outs();
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1);
    run_word(8'h01, W + 1, gl, gm);
    chk("01_lsb_word", 32'(gl), 32'h01);
    chk("01_msb_word", 32'(gm), 32'h01);

    for (int i = 0; i < 400; i++)
      cycle(($urandom % 3) == 0, W'($urandom), ($urandom % 4) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
